// File: rtl/serdes_pkg.sv
// Shared types and constants for the PISO serializer slice.
package serdes_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

  // Counter width for a frame of `width` bits (index range 0..width-1).
  function automatic int cntw(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit index counter for one serial frame; flags the last bit position.
module piso_bit_counter
  import serdes_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = cntw(WIDTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            inc,
  output logic [CNTW-1:0] count,
  output logic            is_last
);

  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(WIDTH - 1);

  logic [CNTW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count   = r_count;
  assign is_last = (r_count == LAST_IDX);

endmodule

// File: rtl/piso_serializer.sv
// Parametrised parallel-in/serial-out serializer with ready/valid load and
// gap-free back-to-back frames.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = ORDER_MSB_FIRST,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int CNTW       = cntw(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             frame_start,
  output logic             frame_done,
  output logic [CNTW-1:0]  bit_count,
  output logic [WIDTH-1:0] shift_reg
);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_frame_start;
  logic             r_frame_done;

  logic             w_is_last;
  logic [CNTW-1:0]  w_count;
  logic             w_in_shift;
  logic             w_last_tick;
  logic             w_accept;
  logic             w_inc;
  logic [WIDTH-1:0] w_shifted;

  assign w_in_shift  = (r_state == ST_SHIFT);
  assign w_last_tick = w_in_shift && enable && w_is_last;
  assign load_ready  = !w_in_shift || w_last_tick;
  assign w_accept    = load_valid && load_ready;
  assign w_inc       = w_in_shift && enable && !w_is_last;

  // Vacated bit is zero-filled, so a fully shifted-out frame leaves zeros.
  assign w_shifted = (MSB_FIRST == ORDER_MSB_FIRST) ? {r_shift[WIDTH-2:0], 1'b0}
                                                    : {1'b0, r_shift[WIDTH-1:1]};

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_bit_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_accept || w_last_tick),
    .inc     (w_inc),
    .count   (w_count),
    .is_last (w_is_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_start <= w_accept;
      r_frame_done  <= w_last_tick;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift <= parallel_in;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (enable) begin
            if (w_accept) begin
              r_shift <= parallel_in;
            end else begin
              r_shift <= w_shifted;
              if (w_is_last) r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign serial_out   = !w_in_shift ? IDLE_LEVEL
                      : (MSB_FIRST == ORDER_MSB_FIRST) ? r_shift[WIDTH-1] : r_shift[0];
  assign busy         = w_in_shift;
  assign serial_valid = w_in_shift;
  assign frame_start  = r_frame_start;
  assign frame_done   = r_frame_done;
  assign bit_count    = w_count;
  assign shift_reg    = r_shift;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: two serializers (MSB-first / LSB-first) share stimulus
// and are compared every cycle against a frame-level model.
module tb_piso_serializer;

  localparam int W    = 8;
  localparam int CW   = $clog2(W);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic load_valid = 1'b0;
  logic [W-1:0] parallel_in = '0;

  logic m_ready, m_sout, m_svalid, m_busy, m_fs, m_fd;
  logic [CW-1:0] m_cnt;
  logic [W-1:0] m_sreg;
  logic l_ready, l_sout, l_svalid, l_busy, l_fs, l_fd;
  logic [CW-1:0] l_cnt;
  logic [W-1:0] l_sreg;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_ready(m_ready), .parallel_in(parallel_in), .serial_out(m_sout),
    .serial_valid(m_svalid), .busy(m_busy), .frame_start(m_fs),
    .frame_done(m_fd), .bit_count(m_cnt), .shift_reg(m_sreg)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_ready(l_ready), .parallel_in(parallel_in), .serial_out(l_sout),
    .serial_valid(l_svalid), .busy(l_busy), .frame_start(l_fs),
    .frame_done(l_fd), .bit_count(l_cnt), .shift_reg(l_sreg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: current frame word, index of the bit on the line.
  logic       x_busy = 1'b0;
  logic [W-1:0] x_data = '0;
  int         x_idx = 0;
  logic       x_fs = 1'b0;
  logic       x_fd = 1'b0;

  function automatic logic model_ready();
    return !x_busy || (enable && x_idx == W - 1);
  endfunction

  always @(posedge clk) begin
    logic acc;
    logic last;
    acc  = load_valid && model_ready();
    last = x_busy && enable && (x_idx == W - 1);
    if (reset) begin
      x_busy = 1'b0; x_idx = 0; x_fs = 1'b0; x_fd = 1'b0;
    end else begin
      x_fs = acc;
      x_fd = last;
      if (acc) begin
        x_data = parallel_in; x_idx = 0; x_busy = 1'b1;
      end else if (last) begin
        x_busy = 1'b0; x_idx = 0;
      end else if (x_busy && enable) begin
        x_idx++;
      end
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] exp_m_sreg, exp_l_sreg;
    logic exp_m_bit, exp_l_bit;
    exp_m_sreg = x_busy ? W'(x_data << x_idx) : '0;
    exp_l_sreg = x_busy ? W'(x_data >> x_idx) : '0;
    exp_m_bit  = x_busy ? x_data[W-1-x_idx] : 1'b0;
    exp_l_bit  = x_busy ? x_data[x_idx]     : 1'b1;
    check("busy",         m_busy,   x_busy);
    check("serial_valid", m_svalid, x_busy);
    check("load_ready",   m_ready,  model_ready());
    check("frame_start",  m_fs,     x_fs);
    check("frame_done",   m_fd,     x_fd);
    check("bit_count",    m_cnt,    x_idx);
    check("msb_serial",   m_sout,   exp_m_bit);
    check("msb_shift",    m_sreg,   exp_m_sreg);
    check("lsb_busy",     l_busy,   x_busy);
    check("lsb_ready",    l_ready,  model_ready());
    check("lsb_serial",   l_sout,   exp_l_bit);
    check("lsb_shift",    l_sreg,   exp_l_sreg);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] cap_m, cap_l;

    // Reset with load_valid and enable held high.
    reset = 1'b1; load_valid = 1'b1; enable = 1'b1; parallel_in = 8'hAA;
    tick();
    tick();
    @(negedge clk);
    check("pin_reset_busy",  m_busy, 1'b0);
    check("pin_reset_ready", m_ready, 1'b1);
    check("pin_reset_sout",  {l_sout, m_sout}, 2'b10);
    check("pin_reset_sreg",  m_sreg, 8'h00);
    check("pin_reset_pulse", {m_fs, m_fd}, 2'b00);

    // Single frame 0xC5, enable every cycle.
    reset = 1'b0; load_valid = 1'b1; parallel_in = 8'hC5; enable = 1'b1;
    tick();
    load_valid = 1'b0; parallel_in = 8'h00;
    cap_m = '0; cap_l = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cap_m = {cap_m[14:0], m_sout};
      cap_l = {cap_l[14:0], l_sout};
      if (i == 0) check("pin_first_start", m_fs, 1'b1);
      tick();
    end
    check("pin_msb_c5", cap_m[7:0], 8'b1100_0101);
    check("pin_lsb_c5", cap_l[7:0], 8'b1010_0011);
    @(negedge clk);
    check("pin_done_idle", {m_fd, m_busy}, 2'b10);
    tick();

    // Back-to-back 0xC5 then 0x3A.
    load_valid = 1'b1; parallel_in = 8'hC5;
    tick();
    parallel_in = 8'h3A;
    cap_m = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cap_m = {cap_m[14:0], m_sout};
      check("pin_b2b_busy", m_busy, 1'b1);
      if (i == 7) check("pin_b2b_ready", m_ready, 1'b1);
      if (i == 8) begin
        check("pin_b2b_pulses", {m_fs, m_fd}, 2'b11);
        load_valid = 1'b0;
      end
      tick();
    end
    check("pin_b2b_bits", cap_m, 16'hC53A);
    tick();

    // Slow enable with ignored mid-frame load.
    enable = 1'b0; load_valid = 1'b1; parallel_in = 8'hC5;
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < 36; c++) begin
      enable = (c % 4 == 3);
      load_valid = (c == 10);
      parallel_in = (c == 10) ? 8'hFF : 8'h00;
      tick();
    end
    enable = 1'b0; load_valid = 1'b0;
    tick();

    // Reset after three bits, then a clean frame.
    enable = 1'b1; load_valid = 1'b1; parallel_in = 8'hC5;
    tick();
    load_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("pin_abort", {m_fd, m_busy, m_sout, l_sout}, 4'b0001);
    load_valid = 1'b1; parallel_in = 8'h3A;
    tick();
    load_valid = 1'b0;
    cap_m = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cap_m = {cap_m[14:0], m_sout};
      tick();
    end
    check("pin_after_abort", cap_m[7:0], 8'h3A);

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      enable      = ($urandom_range(0, 2) != 0);
      load_valid  = ($urandom_range(0, 1) == 1);
      parallel_in = W'($urandom);
      tick();
    end
    reset = 1'b0; enable = 1'b0; load_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
